// File: rtl/uart_xmit.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer that runs off a 16x baud clock.
// Each bit is held for 16 clocks. The PC's RTS line is honoured only between frames.
module uart_xmit #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          uart_sampling_clock,
    input  logic                          rst,
    input  logic [7:0]                    tx_byte,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          USB_RTS,
    output logic                          USB_TX,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [1:0]    state;
    logic [3:0]    sample_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic          push;
    logic          pop;
    logic          can_pop;
    logic          bit_end;

    assign tx_ready = (fifo_count != FULL_CNT);
    assign tx_busy  = (state != S_IDLE);
    assign push     = tx_valid && tx_ready;
    assign bit_end  = (sample_cnt == 4'd15);

    // RTS is only consulted at frame boundaries, so a frame already started always completes.
    assign can_pop  = (fifo_count != '0) && !USB_RTS;
    assign pop      = can_pop && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

    always_ff @(posedge uart_sampling_clock) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= tx_byte;
        end
    end

    always_ff @(posedge uart_sampling_clock) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // USB_TX is registered from the current state, so the line trails the FSM by one clock.
    always_ff @(posedge uart_sampling_clock) begin
        if (rst) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            USB_TX     <= 1'b1;
        end else begin
            case (state)
                S_START: USB_TX <= 1'b0;
                S_DATA:  USB_TX <= shift_reg[0];
                default: USB_TX <= 1'b1;
            endcase

            case (state)
                S_IDLE: begin
                    sample_cnt <= '0;
                    if (pop) begin
                        shift_reg <= fifo_mem[rd_ptr];
                        state     <= S_START;
                    end
                end
                S_START: begin
                    sample_cnt <= sample_cnt + 4'd1;
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    sample_cnt <= sample_cnt + 4'd1;
                    if (bit_end) begin
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    sample_cnt <= sample_cnt + 4'd1;
                    if (bit_end) begin
                        if (pop) begin
                            shift_reg <= fifo_mem[rd_ptr];
                            state     <= S_START;
                        end else begin
                            state     <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge uart_sampling_clock) disable iff (rst)
        fifo_count <= FULL_CNT);
    a_no_underflow: assert property (@(posedge uart_sampling_clock) disable iff (rst)
        pop |-> fifo_count != '0);

endmodule
